// File: rtl/pll_reset_seq.sv
// PLL-lock driven reset sequencer.
// Synchronizes the raw PLL lock, waits for it to stay stable, then releases
// the core-logic reset, waits for RAM initialisation, then releases the RAM
// controller reset. Any loss of lock after leaving WAIT_LOCK restarts the
// sequence and is counted (saturating) and flagged with a one-cycle pulse.
// state_dbg exposes the FSM state for checkers and debug
// (0=WAIT_LOCK, 1=STABLE, 2=RAM_WAIT, 3=RUN).
module pll_reset_seq #(
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_STABLE = 256,
  parameter int RAM_INIT    = 16200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_lock,
  output logic       sys_rst_n,
  output logic       ram_rst_n,
  output logic       ready,
  output logic       lock_lost,
  output logic [7:0] lock_lost_cnt,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    RAM_WAIT  = 2'd2,
    RUN       = 2'd3
  } state_t;

  // Terminal counts; both parameters are bounded to 1..65535 so they fit 16 bits.
  localparam logic [15:0] STABLE_LAST = 16'(LOCK_STABLE - 1);
  localparam logic [15:0] RAM_LAST    = 16'(RAM_INIT - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lock_s;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        sys_d, ram_d, lost_d;
  logic [7:0]  lcnt_d;

  // Lock synchronizer: the only place pll_lock is sampled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], pll_lock};
  end

  assign lock_s    = sync_q[SYNC_STAGES-1];
  assign state_dbg = state_q;

  // Next-state and next-output logic; lock loss overrides any terminal count.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sys_d   = sys_rst_n;
    ram_d   = ram_rst_n;
    lost_d  = 1'b0;
    lcnt_d  = lock_lost_cnt;
    if (state_q != WAIT_LOCK && !lock_s) begin
      state_d = WAIT_LOCK;
      cnt_d   = '0;
      sys_d   = 1'b0;
      ram_d   = 1'b0;
      lost_d  = 1'b1;
      if (lock_lost_cnt != 8'd255) lcnt_d = lock_lost_cnt + 8'd1;
    end else begin
      case (state_q)
        WAIT_LOCK: begin
          if (lock_s) begin
            state_d = STABLE;
            cnt_d   = '0;
          end
        end
        STABLE: begin
          if (cnt_q == STABLE_LAST) begin
            state_d = RAM_WAIT;
            cnt_d   = '0;
            sys_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        RAM_WAIT: begin
          if (cnt_q == RAM_LAST) begin
            state_d = RUN;
            ram_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        RUN: begin
          state_d = RUN;
        end
        default: begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State, counter and registered outputs; ready always tracks ram_rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= WAIT_LOCK;
      cnt_q         <= '0;
      sys_rst_n     <= 1'b0;
      ram_rst_n     <= 1'b0;
      ready         <= 1'b0;
      lock_lost     <= 1'b0;
      lock_lost_cnt <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      sys_rst_n     <= sys_d;
      ram_rst_n     <= ram_d;
      ready         <= ram_d;
      lock_lost     <= lost_d;
      lock_lost_cnt <= lcnt_d;
    end
  end

endmodule

// File: tb/tb_pll_reset_seq.sv
// Testbench for pll_reset_seq with SYNC_STAGES=2, LOCK_STABLE=8, RAM_INIT=20.
// A table of {reset?, pll_lock, edges to run, expected outputs} records is
// applied in order; hand-written sequences cover async reset and saturation.
module tb_pll_reset_seq;

  localparam logic [1:0] S_WAIT = 2'd0;
  localparam logic [1:0] S_STB  = 2'd1;
  localparam logic [1:0] S_RW   = 2'd2;
  localparam logic [1:0] S_RUN  = 2'd3;

  logic       clk;
  logic       rst_n;
  logic       pll_lock;
  logic       sys_rst_n;
  logic       ram_rst_n;
  logic       ready;
  logic       lock_lost;
  logic [7:0] lock_lost_cnt;
  logic [1:0] state_dbg;

  int total;
  int bad;

  pll_reset_seq #(
    .SYNC_STAGES(2),
    .LOCK_STABLE(8),
    .RAM_INIT   (20)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pll_lock     (pll_lock),
    .sys_rst_n    (sys_rst_n),
    .ram_rst_n    (ram_rst_n),
    .ready        (ready),
    .lock_lost    (lock_lost),
    .lock_lost_cnt(lock_lost_cnt),
    .state_dbg    (state_dbg)
  );

  // Clock: 10 ns period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         rst;
    bit         lock;
    int         n;
    logic [1:0] st;
    logic       sys;
    logic       ram;
    logic       rdy;
    int         np;
    int         lc;
  } vec_t;

  vec_t tbl[24];

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] got=%0h want=%0h", name, idx, act, exp);
    end
  endtask

  // Run n rising edges, sampling 1 ns after each; counts lock_lost pulses.
  task automatic run_ticks(input int n, output int np);
    np = 0;
    repeat (n) begin
      @(posedge clk);
      #1;
      if (lock_lost) np++;
    end
  endtask

  // Reset with lock low, release just after a falling edge.
  task automatic do_reset();
    rst_n    = 1'b0;
    pll_lock = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int np;
    int pulses;
    total    = 0;
    bad      = 0;
    rst_n    = 1'b0;
    pll_lock = 1'b0;

    // Clean power-up: sys at edge 10, ram/ready at edge 30.
    tbl[0]  = '{1, 1, 10,  S_STB, 0, 0, 0, 0, 0};
    tbl[1]  = '{0, 1, 1,   S_RW,  1, 0, 0, 0, 0};
    tbl[2]  = '{0, 1, 19,  S_RW,  1, 0, 0, 0, 0};
    tbl[3]  = '{0, 1, 1,   S_RUN, 1, 1, 1, 0, 0};
    tbl[4]  = '{0, 1, 5,   S_RUN, 1, 1, 1, 0, 0};
    // Drop in RUN for 3 cycles, then full sequence repeats.
    tbl[5]  = '{0, 0, 2,   S_RUN, 1, 1, 1, 0, 0};
    tbl[6]  = '{0, 0, 1,   S_WAIT,0, 0, 0, 1, 1};
    tbl[7]  = '{0, 1, 10,  S_STB, 0, 0, 0, 0, 1};
    tbl[8]  = '{0, 1, 1,   S_RW,  1, 0, 0, 0, 1};
    tbl[9]  = '{0, 1, 19,  S_RW,  1, 0, 0, 0, 1};
    tbl[10] = '{0, 1, 1,   S_RUN, 1, 1, 1, 0, 1};
    // Early drop at edge 6, restore at edge 12 -> sys at edge 22.
    tbl[11] = '{1, 1, 6,   S_STB, 0, 0, 0, 0, 0};
    tbl[12] = '{0, 0, 2,   S_STB, 0, 0, 0, 0, 0};
    tbl[13] = '{0, 0, 1,   S_WAIT,0, 0, 0, 1, 1};
    tbl[14] = '{0, 0, 3,   S_WAIT,0, 0, 0, 0, 1};
    tbl[15] = '{0, 1, 10,  S_STB, 0, 0, 0, 0, 1};
    tbl[16] = '{0, 1, 1,   S_RW,  1, 0, 0, 0, 1};
    // Lock held low for 1000 cycles: no progress, no pulse.
    tbl[17] = '{1, 0, 1000,S_WAIT,0, 0, 0, 0, 0};
    // Loss coinciding with the STABLE terminal count wins.
    tbl[18] = '{1, 1, 8,   S_STB, 0, 0, 0, 0, 0};
    tbl[19] = '{0, 0, 2,   S_STB, 0, 0, 0, 0, 0};
    tbl[20] = '{0, 0, 1,   S_WAIT,0, 0, 0, 1, 1};
    // Loss coinciding with the RAM_WAIT terminal count wins.
    tbl[21] = '{1, 1, 28,  S_RW,  1, 0, 0, 0, 0};
    tbl[22] = '{0, 0, 2,   S_RW,  1, 0, 0, 0, 0};
    tbl[23] = '{0, 0, 1,   S_WAIT,0, 0, 0, 1, 1};

    // Asynchronous reset state, before any clock edge.
    #3;
    check("rst_sys",   0, 32'(sys_rst_n),     32'd0);
    check("rst_ram",   0, 32'(ram_rst_n),     32'd0);
    check("rst_rdy",   0, 32'(ready),         32'd0);
    check("rst_lost",  0, 32'(lock_lost),     32'd0);
    check("rst_lcnt",  0, 32'(lock_lost_cnt), 32'd0);
    check("rst_state", 0, 32'(state_dbg),     32'(S_WAIT));

    for (int i = 0; i < 24; i++) begin
      if (tbl[i].rst) do_reset();
      pll_lock = tbl[i].lock;
      run_ticks(tbl[i].n, np);
      check("state",  i, 32'(state_dbg),     32'(tbl[i].st));
      check("sys",    i, 32'(sys_rst_n),     32'(tbl[i].sys));
      check("ram",    i, 32'(ram_rst_n),     32'(tbl[i].ram));
      check("ready",  i, 32'(ready),         32'(tbl[i].rdy));
      check("pulses", i, 32'(np),            32'(tbl[i].np));
      check("lcnt",   i, 32'(lock_lost_cnt), 32'(tbl[i].lc));
    end

    // Async reset in the middle of RAM_WAIT (lock_lost_cnt is 1 here).
    pll_lock = 1'b1;
    run_ticks(20, np);
    check("rw_state", 0, 32'(state_dbg), 32'(S_RW));
    check("rw_sys",   0, 32'(sys_rst_n), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check("ar_sys",   0, 32'(sys_rst_n),     32'd0);
    check("ar_ram",   0, 32'(ram_rst_n),     32'd0);
    check("ar_rdy",   0, 32'(ready),         32'd0);
    check("ar_lost",  0, 32'(lock_lost),     32'd0);
    check("ar_lcnt",  0, 32'(lock_lost_cnt), 32'd0);
    check("ar_state", 0, 32'(state_dbg),     32'(S_WAIT));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_ticks(10, np);
    check("ar_sys_early", 0, 32'(sys_rst_n), 32'd0);
    check("ar_np",        0, 32'(np),        32'd0);
    run_ticks(1, np);
    check("ar_sys_rise",  0, 32'(sys_rst_n), 32'd1);
    check("ar_lcnt2",     0, 32'(lock_lost_cnt), 32'd0);

    // Saturation: 260 loss events from STABLE.
    do_reset();
    pulses = 0;
    for (int i = 0; i < 260; i++) begin
      pll_lock = 1'b1;
      run_ticks(3, np);
      pulses += np;
      pll_lock = 1'b0;
      run_ticks(3, np);
      pulses += np;
      check("sat_pulse", i, 32'(np), 32'd1);
      check("sat_lcnt",  i, 32'(lock_lost_cnt), (i < 255) ? 32'(i + 1) : 32'd255);
    end
    check("sat_total", 0, 32'(pulses), 32'd260);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pll_reset_seq.md
PLL_RESET_SEQ -- requirements
Module: pll_reset_seq

Interface
REQ-001 The module SHALL take parameter SYNC_STAGES, default 2: depth of the pll_lock synchronizer (minimum 2).
REQ-002 The module SHALL take parameter LOCK_STABLE, default 256: consecutive synchronized-lock cycles required before logic reset release (range 1..65535).
REQ-003 The module SHALL take parameter RAM_INIT, default 16200: cycles between logic reset release and RAM reset release, which is 200 us at 81 MHz (range 1..65535).
REQ-004 Port clk  input  1  81 MHz logic clock from the PLL; all sequential logic on its rising edge.
REQ-005 Port rst_n  input  1  asynchronous, active-low reset.
REQ-006 Port pll_lock  input  1  raw PLL lock, asynchronous to clk.
REQ-007 Port sys_rst_n  output  1  active-low reset for core logic, registered.
REQ-008 Port ram_rst_n  output  1  active-low reset for the RAM controller, registered.
REQ-009 Port ready  output  1  high while the sequence is complete and lock holds.
REQ-010 Port lock_lost  output  1  one-cycle pulse for each counted lock-loss event.
REQ-011 Port lock_lost_cnt  output  8  saturating count of lock-loss events.

Function
REQ-012 pll_lock SHALL pass through a SYNC_STAGES flop chain; lock_s denotes the chain output, and no other logic SHALL sample pll_lock.
REQ-013 The FSM SHALL have exactly four states: WAIT_LOCK, STABLE, RAM_WAIT and RUN.
REQ-014 WAIT_LOCK: while lock_s=1, go to STABLE with the counter cleared; otherwise stay.
REQ-015 STABLE: the counter increments each cycle lock_s=1; when it reaches LOCK_STABLE-1 with lock_s=1, go to RAM_WAIT, set sys_rst_n=1 and clear the counter.
REQ-016 RAM_WAIT: the counter increments each cycle; when it reaches RAM_INIT-1 with lock_s=1, go to RUN and set ram_rst_n=1 and ready=1 on the same edge.
REQ-017 RUN: hold all outputs until a lock loss or reset.
REQ-018 Lock loss (lock_s=0 in STABLE, RAM_WAIT or RUN) SHALL, on the next edge, set sys_rst_n=0, ram_rst_n=0, ready=0, clear the counter, enter WAIT_LOCK and pulse lock_lost for one cycle.
REQ-019 On the same edge as REQ-018, lock_lost_cnt SHALL increment, saturating at 255.
REQ-020 lock_s=0 in WAIT_LOCK SHALL NOT be counted and SHALL NOT pulse lock_lost.
REQ-021 Lock loss SHALL take priority over any counter terminal condition on the same cycle.
REQ-022 Outputs SHALL obey: ram_rst_n=1 implies sys_rst_n=1, and ready equals ram_rst_n at every edge.
REQ-023 Latency: with pll_lock rising and held before edge E0, sys_rst_n SHALL rise at edge E0+SYNC_STAGES+LOCK_STABLE.
REQ-024 ram_rst_n SHALL rise exactly RAM_INIT edges after sys_rst_n rises.
REQ-025 The counter SHALL be 16 bits and SHALL never wrap within a state.
REQ-026 A pll_lock glitch shorter than one clk period SHALL either be filtered entirely or be treated as a full loss, with no intermediate output state.

Reset
REQ-027 rst_n=0 SHALL immediately and asynchronously force synchronizer flops=0, state=WAIT_LOCK, counter=0, sys_rst_n=0, ram_rst_n=0, ready=0, lock_lost=0 and lock_lost_cnt=0.
REQ-028 Reset deassertion SHALL be taken synchronously; the sequence restarts from WAIT_LOCK even when pll_lock is already high.
REQ-029 rst_n asserted mid-sequence in any state SHALL abort the sequence without counting a lock loss.

Verification (bench parameters: SYNC_STAGES=2, LOCK_STABLE=8, RAM_INIT=20)
REQ-030 Clean power-up: release rst_n, then raise pll_lock before edge 0 -> sys_rst_n rises at edge 10; ram_rst_n and ready rise at edge 30; lock_lost stays 0; lock_lost_cnt=0.
REQ-031 Early drop: drop pll_lock during STABLE (edge 6), restore at edge 12 -> lock_lost pulses once; lock_lost_cnt=1; sys_rst_n stays 0 until 10 edges after the restore.
REQ-032 Drop in RUN: drop pll_lock for 3 cycles while in RUN -> all three reset outputs low on the edge after lock_s falls; lock_lost_cnt increments by 1; full sequence repeats.
REQ-033 Saturation: force 260 lock-loss events -> lock_lost_cnt=255 and lock_lost still pulses on each event.
REQ-034 Reset mid-RAM_WAIT: assert rst_n mid-RAM_WAIT -> all outputs 0 with no clk edge, lock_lost_cnt=0; after release with lock held, sys_rst_n rises 10 edges later.
REQ-035 Wait state: hold pll_lock low for 1000 cycles -> state stays WAIT_LOCK, sys_rst_n=0, no lock_lost pulse.
